// File: rtl/ms_pkg.sv
// ms_pkg: shared state encodings and board geometry for the Minesweeper game sequencer.
package ms_pkg;

    localparam int N_CELLS        = 25;
    localparam int ADDR_W         = 5;
    localparam int MOVE_W         = 8;
    localparam int TIMEOUT_CYCLES = 16;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] PLACE   = 4'd1;
    localparam logic [3:0] WAIT_IN = 4'd2;
    localparam logic [3:0] LOAD    = 4'd3;
    localparam logic [3:0] DECODE  = 4'd4;
    localparam logic [3:0] ALU     = 4'd5;
    localparam logic [3:0] DISPLAY = 4'd6;
    localparam logic [3:0] LOSE    = 4'd7;
    localparam logic [3:0] WIN     = 4'd8;
    localparam logic [3:0] FAULT   = 4'd9;

    // States that wait on a unit's done handshake.
    function automatic logic is_phase(input logic [3:0] s);
        return s == PLACE || s == DECODE || s == ALU || s == DISPLAY;
    endfunction

endpackage

// File: rtl/ms_phase_watchdog.sv
// ms_phase_watchdog: counts cycles spent in one handshake phase and flags the last allowed cycle.
module ms_phase_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = cnt_q == CW'(LIMIT - 1);
    assign cnt_d    = clr_i ? '0 : expire_o ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

endmodule

// File: rtl/ms_game_sequencer.sv
// ms_game_sequencer: Minesweeper game controller sequencing placement, move capture, decode, ALU and display.
// Optional phase watchdog enabled by defining MS_SEQ_WATCHDOG_EN.
module ms_game_sequencer
    import ms_pkg::*;
(
    input  logic              in_clka,
    input  logic              in_restart_n,
    input  logic              in_restart,
    input  logic              in_place,
    input  logic              in_data_in,
    input  logic [ADDR_W-1:0] in_data,
    input  logic [N_CELLS-1:0] in_cleared,
    input  logic              in_place_done,
    input  logic              in_decode_done,
    input  logic              in_alu_done,
    input  logic              in_gameover,
    input  logic              in_win,
    input  logic              in_display_done,
    output logic [3:0]        out_state_main,
    output logic              out_start,
    output logic              out_load,
    output logic              out_decode,
    output logic              out_alu,
    output logic              out_display,
    output logic [ADDR_W-1:0] out_temp_data_in,
    output logic [MOVE_W-1:0] out_move_count,
    output logic              out_reject,
    output logic              out_timeout
);

    logic [3:0]            state_q, state_d;
    logic [ADDR_W-1:0]     temp_q;
    logic [MOVE_W-1:0]     count_q;
    logic                  reject_q, timeout_q, expire, bad_move, try_move, accept;
    logic [2**ADDR_W-1:0]  cleared_ext;

    // Widen the cleared mask so out-of-range indices read a defined zero.
    assign cleared_ext = {{(2**ADDR_W - N_CELLS){1'b0}}, in_cleared};
    assign bad_move    = in_data >= ADDR_W'(N_CELLS) || cleared_ext[in_data];
    assign try_move    = !in_restart && state_q == WAIT_IN && in_data_in;
    assign accept      = try_move && !bad_move;

`ifdef MS_SEQ_WATCHDOG_EN
    ms_phase_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i    (in_clka),
        .rst_ni   (in_restart_n),
        .clr_i    (state_d != state_q || !is_phase(state_q)),
        .expire_o (expire)
    );

    always_ff @(posedge in_clka or negedge in_restart_n)
        if (!in_restart_n) timeout_q <= 1'b0;
        else               timeout_q <= !in_restart && (timeout_q || (state_d == FAULT && state_q != FAULT));
`else
    assign expire    = 1'b0;
    assign timeout_q = 1'b0;
`endif

    always_ff @(posedge in_clka or negedge in_restart_n)
        if (!in_restart_n) begin
            state_q  <= IDLE;
            temp_q   <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            temp_q   <= in_restart ? '0 : accept ? in_data : temp_q;
            count_q  <= in_restart ? '0 : (accept && count_q != '1) ? count_q + 1'b1 : count_q;
            reject_q <= try_move && bad_move;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_place ? PLACE : IDLE;
            PLACE:   state_d = in_place_done ? WAIT_IN : expire ? FAULT : PLACE;
            WAIT_IN: state_d = accept ? LOAD : WAIT_IN;
            LOAD:    state_d = DECODE;
            DECODE:  state_d = in_decode_done ? ALU : expire ? FAULT : DECODE;
            ALU:     state_d = !in_alu_done ? (expire ? FAULT : ALU) : in_gameover ? LOSE : in_win ? WIN : DISPLAY;
            DISPLAY: state_d = in_display_done ? WAIT_IN : expire ? FAULT : DISPLAY;
            default: state_d = state_q;
        endcase
        if (in_restart) state_d = IDLE;
    end

    always_comb begin
        out_state_main   = state_q;
        out_start        = state_q == PLACE;
        out_load         = state_q == LOAD;
        out_decode       = state_q == DECODE;
        out_alu          = state_q == ALU;
        out_display      = state_q == DISPLAY;
        out_temp_data_in = temp_q;
        out_move_count   = count_q;
        out_reject       = reject_q;
        out_timeout      = timeout_q;
    end

endmodule

// File: tb/tb_ms_game_sequencer.sv
// tb_ms_game_sequencer: directed bench with a cycle-level game model checked on every falling edge.
module tb_ms_game_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, restart, place, data_in, place_done, decode_done, alu_done, gameover, win, display_done;
    logic [4:0]  data;
    logic [24:0] cleared;
    logic [3:0]  out_state_main;
    logic        out_start, out_load, out_decode, out_alu, out_display, out_reject, out_timeout;
    logic [4:0]  out_temp_data_in;
    logic [7:0]  out_move_count;

    ms_game_sequencer dut (
        .in_clka(clk), .in_restart_n(rst_n), .in_restart(restart), .in_place(place),
        .in_data_in(data_in), .in_data(data), .in_cleared(cleared), .in_place_done(place_done),
        .in_decode_done(decode_done), .in_alu_done(alu_done), .in_gameover(gameover), .in_win(win),
        .in_display_done(display_done), .out_state_main(out_state_main), .out_start(out_start),
        .out_load(out_load), .out_decode(out_decode), .out_alu(out_alu), .out_display(out_display),
        .out_temp_data_in(out_temp_data_in), .out_move_count(out_move_count),
        .out_reject(out_reject), .out_timeout(out_timeout)
    );

    int total = 0, bad = 0, start_cycles = 0;
    int m_state = 0, m_cnt = 0, m_temp = 0, m_age = 0;
    bit m_rej = 0, m_to = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Game model: advances one step per rising edge from the inputs the DUT just sampled.
    always @(posedge clk) begin
        int prev;
        bit r;
        #1;
        prev = m_state;
        r = 0;
        if (!rst_n || restart) begin
            m_state = 0; m_cnt = 0; m_temp = 0; m_to = 0;
        end else begin
            case (m_state)
                0: if (place) m_state = 1;
                1: if (place_done) m_state = 2;
                2: if (data_in) begin
                       if (data >= 25) r = 1;
                       else if (cleared[data]) r = 1;
                       else begin
                           m_temp = data;
                           if (m_cnt < 255) m_cnt++;
                           m_state = 3;
                       end
                   end
                3: m_state = 4;
                4: if (decode_done) m_state = 5;
                5: if (alu_done) m_state = gameover ? 7 : (win ? 8 : 6);
                6: if (display_done) m_state = 2;
                default: ;
            endcase
`ifdef MS_SEQ_WATCHDOG_EN
            if (prev inside {1, 4, 5, 6} && m_state == prev) begin
                m_age++;
                if (m_age == 16) begin
                    m_state = 9;
                    m_to = 1;
                end
            end
`endif
        end
        if (m_state != prev || !rst_n || restart) m_age = 0;
        m_rej = r;
    end

    always @(negedge clk) begin
        chk("state", out_state_main, m_state);
        chk("cmds", {out_start, out_load, out_decode, out_alu, out_display},
            {m_state == 1, m_state == 3, m_state == 4, m_state == 5, m_state == 6});
        chk("temp", out_temp_data_in, m_temp);
        chk("count", out_move_count, m_cnt);
        chk("reject", out_reject, m_rej);
        chk("timeout", out_timeout, m_to);
        if (out_start) start_cycles++;
    end

    task automatic do_move(input logic [4:0] c, input logic go, input logic w);
        data = c; data_in = 1; tick(); data_in = 0;
        tick();
        decode_done = 1; tick(); decode_done = 0;
        gameover = go; win = w; alu_done = 1; tick(); alu_done = 0; gameover = 0; win = 0;
        if (!go && !w) begin display_done = 1; tick(); display_done = 0; end
    endtask

    task automatic new_game();
        restart = 1; tick(); restart = 0;
        place = 1; tick(); place = 0;
        place_done = 1; tick(); place_done = 0;
    endtask

    initial begin
        rst_n = 0; restart = 0; place = 0; data_in = 0; place_done = 0; decode_done = 0;
        alu_done = 0; gameover = 0; win = 0; display_done = 0; data = 0; cleared = '0;
        #3;
        chk("rst_state", out_state_main, 0);
        chk("rst_outs", {out_start, out_load, out_decode, out_alu, out_display, out_reject, out_timeout,
                         out_temp_data_in, out_move_count}, 0);
        tick();
        rst_n = 1;

        // 1: placement handshake
        place = 1; tick(); place = 0;
        chk("t1_place", out_state_main, 1);
        tick(2);
        place_done = 1; tick(); place_done = 0;
        chk("t1_wait", out_state_main, 2);
        chk("t1_start_cycles", start_cycles, 3);

        // place and stray dones in WAIT_IN are ignored
        place = 1; decode_done = 1; display_done = 1; tick();
        place = 0; decode_done = 0; display_done = 0;
        chk("t1_ignore", out_state_main, 2);

        // 2: first move
        data = 2; data_in = 1; tick(); data_in = 0;
        chk("t2_load", {out_state_main, out_load}, {4'd3, 1'b1});
        chk("t2_temp", out_temp_data_in, 2);
        chk("t2_count", out_move_count, 1);
        tick();
        chk("t2_decode", {out_state_main, out_load, out_decode}, {4'd4, 1'b0, 1'b1});
        alu_done = 1; tick(); alu_done = 0;
        chk("t2_stray_alu", out_state_main, 4);
        decode_done = 1; tick(); decode_done = 0;
        alu_done = 1; tick(); alu_done = 0;
        chk("t2_display", out_state_main, 6);
        display_done = 1; tick(); display_done = 0;
        chk("t2_back", out_state_main, 2);

        // 3: rejects
        cleared[2] = 1;
        data = 25; data_in = 1; tick();
        chk("t3_rej_range", {out_state_main, out_reject, out_move_count}, {4'd2, 1'b1, 8'd1});
        data = 2; tick(); data_in = 0;
        chk("t3_rej_cleared", {out_state_main, out_reject, out_move_count}, {4'd2, 1'b1, 8'd1});
        tick();
        chk("t3_rej_drop", out_reject, 0);

        // 4: gameover beats win
        do_move(5'd7, 1'b1, 1'b1);
        chk("t4_lose", out_state_main, 7);
        display_done = 1; place = 1; data_in = 1; tick(); display_done = 0; place = 0; data_in = 0;
        chk("t4_hold", out_state_main, 7);
        restart = 1; tick(); restart = 0;
        chk("t4_restart", {out_state_main, out_move_count, out_temp_data_in}, 0);

        // win path
        new_game();
        do_move(5'd3, 1'b0, 1'b1);
        chk("t4_win", {out_state_main, out_move_count, out_temp_data_in}, {4'd8, 8'd1, 5'd3});

        // 5: restart beats a move in WAIT_IN
        new_game();
        data = 4; data_in = 1; restart = 1; tick(); data_in = 0; restart = 0;
        chk("t5_idle", {out_state_main, out_temp_data_in, out_move_count, out_load}, 0);
        tick();
        chk("t5_noload", out_load, 0);

        // 6: watchdog
        new_game();
        data = 5; data_in = 1; tick(); data_in = 0;
        tick();
`ifdef MS_SEQ_WATCHDOG_EN
        tick(15);
        chk("t6_before", out_state_main, 4);
        tick();
        chk("t6_fault", {out_state_main, out_timeout}, {4'd9, 1'b1});
        restart = 1; tick(); restart = 0;
        chk("t6_clear", {out_state_main, out_timeout}, 0);
        place = 1; tick(); place = 0;
        place_done = 1; tick(); place_done = 0;
        data = 5; data_in = 1; tick(); data_in = 0;
        tick();
        tick(15);
        decode_done = 1; tick(); decode_done = 0;
        chk("t6_done_wins", {out_state_main, out_timeout}, {4'd5, 1'b0});
`else
        tick(40);
        chk("t6_no_wd", {out_state_main, out_timeout}, {4'd4, 1'b0});
        decode_done = 1; tick(); decode_done = 0;
        chk("t6_alu", out_state_main, 5);
`endif

        // move counter saturates
        cleared = '0;
        new_game();
        for (int i = 0; i < 256; i++) do_move(5'(i % 25), 1'b0, 1'b0);
        chk("sat_count", out_move_count, 255);
        chk("sat_state", out_state_main, 2);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
